// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared sequencer state encoding and SPI-core register map
// for the SPI transfer sequencer and its arbiter.
package spi_seq_pkg;
   typedef enum logic [2:0] {IDLE, SS_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, SS_OFF, DONE} seq_state_e;
   localparam logic [2:0] ADDR_RXDATA   = 3'd0;
   localparam logic [2:0] ADDR_TXDATA   = 3'd1;
   localparam logic [2:0] ADDR_STATUS   = 3'd2;
   localparam logic [2:0] ADDR_CONTROL  = 3'd3;
   localparam logic [2:0] ADDR_SLAVESEL = 3'd5;
   localparam logic [2:0] ADDR_EOPVAL   = 3'd6;
   localparam logic [15:0] CTRL_SSO     = 16'h0400;
   function automatic logic is_access(input seq_state_e s);
      return s inside {SS_ON, TX_WR, RX_RD, SS_OFF};
   endfunction
endpackage

// File: rtl/spi_rr_arb2.sv
// spi_rr_arb2: two-way round-robin arbiter; on a tie the requester not
// served last wins, and the pointer moves only when a grant is taken.
module spi_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);
   logic prio_q, prio_d;
   assign gnt = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
   assign prio_d = (upd && |req) ? gnt[0] : prio_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) prio_q <= 1'b0;
      else       prio_q <= prio_d;
endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: arbitrates two requesters and runs one-byte-in-flight
// SPI transactions through 2-cycle register accesses to an SPI core.
module spi_xfer_sequencer
   import spi_seq_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] req_len_0,
   input  logic [LEN_W-1:0] req_len_1,
   output logic [1:0]       gnt,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic [1:0]       done,
   output logic [2:0]       spi_addr,
   output logic [15:0]      spi_wdata,
   output logic             spi_select,
   output logic             spi_read_n,
   output logic             spi_write_n,
   input  logic [15:0]      spi_rdata,
   input  logic             spi_trdy,
   input  logic             spi_rrdy
);
   seq_state_e state_q, state_d;
   logic ph_q, ph_d;
   logic [LEN_W-1:0] cnt_q, cnt_d, len_raw, len_sat;
   logic [1:0] gnt_q, gnt_d, arb_gnt;
   logic [7:0] txb_q, txb_d, rx_q, rx_d;
   logic rxv_q, rxv_d, acc;
   logic unused_rdata_hi;
   assign unused_rdata_hi = ^spi_rdata[15:8];
   spi_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .upd   (state_q == IDLE),
      .gnt   (arb_gnt)
   );
   assign len_raw = arb_gnt[1] ? req_len_1 : req_len_0;
   assign len_sat = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw;
   assign acc = is_access(state_q);
   // ph_q marks the second cycle of a 2-cycle access; it wraps so accesses can run back to back
   always_comb begin
      state_d = state_q;
      ph_d    = acc ? ~ph_q : 1'b0;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      txb_d   = txb_q;
      rx_d    = rx_q;
      rxv_d   = 1'b0;
      case (state_q)
         IDLE:    if (|req) begin
                     gnt_d   = arb_gnt;
                     cnt_d   = len_sat;
                     state_d = (len_sat == '0) ? DONE : SS_ON;
                  end
         SS_ON:   state_d = ph_q ? TX_WAIT : SS_ON;
         TX_WAIT: if (spi_trdy) begin
                     txb_d   = tx_data;
                     state_d = TX_WR;
                  end
         TX_WR:   state_d = ph_q ? RX_WAIT : TX_WR;
         RX_WAIT: state_d = spi_rrdy ? RX_RD : RX_WAIT;
         RX_RD:   if (ph_q) begin
                     rx_d    = spi_rdata[7:0];
                     rxv_d   = 1'b1;
                     cnt_d   = cnt_q - 1'b1;
                     state_d = (cnt_q == LEN_W'(1)) ? SS_OFF : TX_WAIT;
                  end
         SS_OFF:  state_d = ph_q ? DONE : SS_OFF;
         DONE:    begin
                     gnt_d   = 2'b00;
                     state_d = IDLE;
                  end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         ph_q    <= 1'b0;
         cnt_q   <= '0;
         gnt_q   <= 2'b00;
         txb_q   <= 8'h00;
         rx_q    <= 8'h00;
         rxv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         txb_q   <= txb_d;
         rx_q    <= rx_d;
         rxv_q   <= rxv_d;
      end
   assign spi_select  = acc;
   assign spi_read_n  = !(state_q == RX_RD);
   assign spi_write_n = !(acc && state_q != RX_RD);
   assign spi_addr    = (state_q inside {SS_ON, SS_OFF}) ? ADDR_CONTROL :
                        (state_q == TX_WR) ? ADDR_TXDATA : ADDR_RXDATA;
   assign spi_wdata   = (state_q == SS_ON) ? CTRL_SSO :
                        (state_q == TX_WR) ? {8'h00, txb_q} : 16'h0000;
   assign tx_ready    = (state_q == TX_WR) && ph_q;
   assign done        = (state_q == DONE) ? gnt_q : 2'b00;
   assign gnt         = gnt_q;
   assign rx_data     = rx_q;
   assign rx_valid    = rxv_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: directed checks of the SPI transfer sequencer
// against a small SPI-core/MISO model that logs register accesses.
module tb_spi_xfer_sequencer;
   logic clk = 1'b0, reset = 1'b1;
   logic [1:0] req = 2'b00;
   logic [4:0] req_len_0 = '0, req_len_1 = '0;
   logic [7:0] tx_data = 8'h00;
   logic spi_trdy = 1'b0, spi_rrdy = 1'b0;
   logic [15:0] spi_rdata = 16'h0000;
   logic [1:0] gnt, done;
   logic tx_ready, rx_valid, spi_select, spi_read_n, spi_write_n;
   logic [7:0] rx_data;
   logic [2:0] spi_addr;
   logic [15:0] spi_wdata;
   spi_xfer_sequencer #(.MAX_LEN(16), .LEN_W(5)) dut (
      .clk(clk), .reset(reset), .req(req), .req_len_0(req_len_0), .req_len_1(req_len_1),
      .gnt(gnt), .tx_data(tx_data), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .done(done), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_select(spi_select),
      .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata),
      .spi_trdy(spi_trdy), .spi_rrdy(spi_rrdy)
   );
   always #5 clk = ~clk;
   int errs = 0, checks = 0;
   int nev = 0, acc_cyc = 0, ntxr = 0, nrx = 0, ndone = 0;
   int tx_mark = 0;
   logic [7:0] tx_base = 8'h00;
   logic trdy_en = 1'b1, rrdy_en = 1'b1;
   logic [31:0] seq = '0;
   logic [15:0] last_tx = '0;
   logic [21:0] prev_sig = '0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // SPI core model: event log (1=SSO set, 2=TX write, 3=RX read, 4=SSO clear) and MISO bytes 0x3C+n
   initial forever begin
      logic [21:0] sig;
      logic [3:0] ev;
      @(negedge clk);
      sig = {spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata};
      if (spi_select) begin
         acc_cyc++;
         if (sig != prev_sig) begin
            ev = !spi_read_n ? 4'd3 : (spi_addr == 3'd1) ? 4'd2 : (spi_wdata == 16'h0400) ? 4'd1 : 4'd4;
            seq = {seq[27:0], ev};
            nev++;
            if (ev == 4'd2) last_tx = spi_wdata;
         end
      end
      prev_sig = sig;
      if (tx_ready) ntxr++;
      if (rx_valid) begin
         chk("rx_byte", {24'h0, rx_data}, {24'h0, 8'h3C + 8'(nrx)});
         nrx++;
      end
      if (done != 2'b00) ndone++;
      if (tx_ready && rrdy_en) spi_rrdy = 1'b1;
      if (reset || (spi_select && !spi_read_n)) spi_rrdy = 1'b0;
      spi_trdy  = trdy_en;
      spi_rdata = {8'hEE, 8'h3C + 8'(nrx)};
      tx_data   = tx_base + 8'(ntxr - tx_mark);
   end
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask
   task automatic start(input logic [1:0] r, input logic [4:0] l0, input logic [4:0] l1,
                        output logic [1:0] g, output logic [1:0] d);
      req = r; req_len_0 = l0; req_len_1 = l1; g = 2'b00; d = 2'b00;
      for (int i = 0; i < 20 && g == 2'b00; i++) begin
         cyc();
         g = gnt;
         d = done;
      end
      req = 2'b00; req_len_0 = 5'd31; req_len_1 = 5'd31;
   endtask
   task automatic wait_done(output logic [1:0] d);
      d = 2'b00;
      for (int i = 0; i < 300 && d == 2'b00; i++) begin
         cyc();
         d = done;
      end
   endtask
   task automatic chk_reset_outs(input string t);
      chk({t, "_gnt"}, gnt, 0);
      chk({t, "_done"}, done, 0);
      chk({t, "_select"}, spi_select, 0);
      chk({t, "_read_n"}, spi_read_n, 1);
      chk({t, "_write_n"}, spi_write_n, 1);
      chk({t, "_addr"}, spi_addr, 0);
      chk({t, "_wdata"}, spi_wdata, 0);
      chk({t, "_rx_data"}, rx_data, 0);
      chk({t, "_rx_valid"}, rx_valid, 0);
      chk({t, "_tx_ready"}, tx_ready, 0);
   endtask
   initial begin
      logic [1:0] g, d;
      int b_nev, b_acc, b_txr, b_rx, b_done;
      cyc(); cyc();
      chk_reset_outs("rst");
      reset = 1'b0;
      // single byte
      tx_base = 8'hA5; tx_mark = ntxr;
      b_nev = nev; b_acc = acc_cyc; b_txr = ntxr; b_rx = nrx;
      start(2'b01, 5'd1, 5'd0, g, d);
      chk("t1_gnt", g, 2'b01);
      wait_done(d);
      chk("t1_done", d, 2'b01);
      chk("t1_seq", seq[15:0], 16'h1234);
      chk("t1_events", nev - b_nev, 4);
      chk("t1_acc_cycles", acc_cyc - b_acc, 8);
      chk("t1_tx_wdata", last_tx, 16'h00A5);
      chk("t1_rx_data", rx_data, 8'h3C);
      chk("t1_tx_ready", ntxr - b_txr, 1);
      chk("t1_rx_valid", nrx - b_rx, 1);
      // tie after reset, with one-cycle gap before the next grant
      reset = 1'b1; cyc(); cyc(); reset = 1'b0;
      req_len_0 = 5'd1; req_len_1 = 5'd1; req = 2'b11; g = 2'b00;
      for (int i = 0; i < 20 && g == 2'b00; i++) begin
         cyc();
         g = gnt;
      end
      chk("tie_first", g, 2'b01);
      req = 2'b10;
      wait_done(d);
      chk("tie_done0", d, 2'b01);
      cyc();
      chk("tie_gap", gnt, 2'b00);
      cyc();
      chk("tie_second", gnt, 2'b10);
      req = 2'b00;
      wait_done(d);
      chk("tie_done1", d, 2'b10);
      start(2'b11, 5'd1, 5'd1, g, d);
      chk("tie_again", g, 2'b01);
      wait_done(d);
      chk("tie_again_done", d, 2'b01);
      // three-byte burst under a single SSO window
      tx_base = 8'h11; tx_mark = ntxr;
      b_nev = nev; b_acc = acc_cyc; b_txr = ntxr; b_rx = nrx;
      start(2'b01, 5'd3, 5'd0, g, d);
      chk("burst_gnt", g, 2'b01);
      wait_done(d);
      chk("burst_done", d, 2'b01);
      chk("burst_seq", seq, 32'h12323234);
      chk("burst_events", nev - b_nev, 8);
      chk("burst_acc_cycles", acc_cyc - b_acc, 16);
      chk("burst_tx_ready", ntxr - b_txr, 3);
      chk("burst_rx_valid", nrx - b_rx, 3);
      chk("burst_last_tx", last_tx, 16'h0013);
      // length above MAX_LEN saturates
      b_txr = ntxr; b_rx = nrx;
      start(2'b10, 5'd0, 5'd31, g, d);
      chk("sat_gnt", g, 2'b10);
      wait_done(d);
      chk("sat_done", d, 2'b10);
      chk("sat_tx_ready", ntxr - b_txr, 16);
      chk("sat_rx_valid", nrx - b_rx, 16);
      // zero length: done alongside the grant, no access
      b_acc = acc_cyc;
      start(2'b01, 5'd0, 5'd0, g, d);
      chk("zero_gnt", g, 2'b01);
      chk("zero_done", d, 2'b01);
      cyc();
      chk("zero_done_pulse", done, 2'b00);
      chk("zero_gnt_clr", gnt, 2'b00);
      chk("zero_no_select", acc_cyc - b_acc, 0);
      // TX stall, then reset while waiting for RX
      trdy_en = 1'b0;
      b_nev = nev; b_txr = ntxr;
      start(2'b01, 5'd1, 5'd0, g, d);
      repeat (100) cyc();
      chk("stall_seq", seq[3:0], 4'h1);
      chk("stall_events", nev - b_nev, 1);
      chk("stall_tx_ready", ntxr - b_txr, 0);
      rrdy_en = 1'b0; trdy_en = 1'b1;
      for (int i = 0; i < 20 && ntxr == b_txr; i++) cyc();
      chk("stall_resume_tx", ntxr - b_txr, 1);
      cyc(); cyc(); cyc();
      b_done = ndone;
      #2 reset = 1'b1;
      #1 chk_reset_outs("midrst");
      cyc(); cyc();
      reset = 1'b0; rrdy_en = 1'b1;
      repeat (10) cyc();
      chk("midrst_no_done", ndone - b_done, 0);
      chk("midrst_gnt_idle", gnt, 2'b00);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, 16, maximum bytes per transaction.
REQ-002 SHALL have parameter LEN_W, 5, width of the length fields.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  2  per-requester transaction request, bit i = requester i.
REQ-006 SHALL have ports req_len_0 and req_len_1  in  LEN_W  byte count for each requester.
REQ-007 SHALL have port gnt  out  2  one-hot grant; held for the whole transaction.
REQ-008 SHALL have ports tx_data  in  8 (granted requester's next byte) and tx_ready  out  1 (one-cycle pulse: byte consumed).
REQ-009 SHALL have ports rx_data  out  8 and rx_valid  out  1 (one-cycle pulse: received byte valid).
REQ-010 SHALL have port done  out  2  one-cycle pulse on the bit of the requester whose transaction ended.
REQ-011 SHALL have SPI-core register-port outputs spi_addr (3), spi_wdata (16), spi_select (1), spi_read_n (1) and spi_write_n (1).
REQ-012 SHALL have SPI-core inputs spi_rdata  in  16, spi_trdy  in  1 (readyfordata) and spi_rrdy  in  1 (dataavailable).

Function
REQ-013 SHALL implement states IDLE, SS_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, SS_OFF, DONE.
REQ-014 SHALL, in IDLE, register a round-robin grant when req is non-zero and go to SS_ON the next cycle; on a tie, grant the requester not served last.
REQ-015 SHALL latch the granted length at grant time; later changes to req and req_len are ignored until done.
REQ-016 SHALL saturate latched lengths above MAX_LEN to MAX_LEN.
REQ-017 SHALL, for a latched length of 0, go directly to DONE without asserting spi_select.
REQ-018 SHALL make every register access exactly 2 cycles: spi_select asserted and spi_read_n or spi_write_n low, with spi_addr and spi_wdata stable in both cycles.
REQ-019 SHALL, between accesses, hold spi_select=0, spi_read_n=1 and spi_write_n=1.
REQ-020 SHALL, in SS_ON, write 0x0400 (SSO set) to addr 3, then go to TX_WAIT.
REQ-021 SHALL remain in TX_WAIT while spi_trdy=0, with no timeout; when spi_trdy=1, go to TX_WR.
REQ-022 SHALL, in TX_WR, write {8'h00, tx_data} to addr 1, pulsing tx_ready in the second cycle, then go to RX_WAIT.
REQ-023 SHALL remain in RX_WAIT while spi_rrdy=0; when spi_rrdy=1, go to RX_RD.
REQ-024 SHALL, in RX_RD, read addr 0 and capture spi_rdata[7:0] in the second cycle, driving rx_data and pulsing rx_valid the cycle after.
REQ-025 SHALL decrement the remaining count on each rx capture; nonzero goes to TX_WAIT, zero goes to SS_OFF.
REQ-026 SHALL limit traffic to one byte in flight: TX_WR is never entered before the previous byte's RX_RD.
REQ-027 SHALL, in SS_OFF, write 0x0000 to addr 3, then enter DONE.
REQ-028 SHALL, in DONE, pulse done[granted] for one cycle, clear gnt and return to IDLE; a new grant can occur no earlier than the next cycle.
REQ-029 SHALL keep SS asserted continuously across all bytes of one transaction.

Reset
REQ-030 SHALL, on reset, force state=IDLE, gnt=0, done=0, tx_ready=0, rx_valid=0, rx_data=0x00, spi_select=0, spi_read_n=1, spi_write_n=1, spi_addr=0, spi_wdata=0 and round-robin pointer favouring requester 0, all asynchronously.
REQ-031 SHALL, on reset mid-transaction, abandon it without a done pulse; the SPI core shares the same reset, which clears SSO.

Structure
REQ-032 SHALL take state encoding, SPI register addresses (RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3, SLAVESEL=5, EOPVAL=6) and CTRL_SSO=0x0400 from shared package spi_seq_pkg.
REQ-033 SHALL contain one sub-module, spi_rr_arb2 (2-way round-robin arbiter); the 2-cycle access driver stays inline.

Verification
REQ-034 SHALL test a single byte: req=01, len 1, tx 0xA5, MISO model returns 0x3C -> writes 0x0400@3, 0x00A5@1, then read @0; rx_data=0x3C with rx_valid; write 0x0000@3; done=01.
REQ-035 SHALL test a tie: req=11 in the same cycle after reset -> gnt=01 first, then gnt=10 after done=01; then req=11 again -> gnt=01.
REQ-036 SHALL test a burst: len 3 -> 3 tx_ready pulses, 3 rx_valid pulses, exactly one SSO set and one SSO clear, SS_n low throughout.
REQ-037 SHALL test a zero length: len 0 -> done pulse within 2 cycles of grant, spi_select never asserted.
REQ-038 SHALL test stall and reset: spi_trdy held 0 for 100 cycles -> no addr 1 write; reset asserted in RX_WAIT -> all outputs at reset values, gnt=00, no done.
